bypass_seq_ctrl: RTL

Sequences the bypass datapath for the three move-class ops: lui, mv.w.x (int -> fp) and mv.x.w (fp -> int).
- Accepts one decoded op per transaction over a valid/ready handshake.
- Issues the source register-file read and drives bypass_sel to the bypass mux.
- Captures the mux result, then shares the register-file writeback ports with the ALU, which has priority.
- Sits between decode and the int/fp register files, alongside the ALU writeback path.

---
 rtl/bypass_pkg.sv | 23 ++
 rtl/bypass_seq_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bypass_pkg.sv
// Shared definitions for the move-class bypass sequencer: op/select
// encoding, FSM state type and the destination-file helper.
package bypass_pkg;

  // op_type and bypass_sel share one encoding.
  localparam logic [1:0] BYP_NONE = 2'b00;
  localparam logic [1:0] BYP_LUI  = 2'b01;
  localparam logic [1:0] BYP_MVWX = 2'b10;
  localparam logic [1:0] BYP_MVXW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_CAPT = 2'b10,
    ST_WB   = 2'b11
  } state_t;

  // lui and mv.x.w write the int file; mv.w.x writes the fp file.
  function automatic logic dst_is_int(input logic [1:0] op);
    return (op == BYP_LUI) || (op == BYP_MVXW);
  endfunction

endpackage

// File: rtl/bypass_seq_ctrl.sv
// Bypass datapath sequencer for lui, mv.w.x and mv.x.w.
// Flow: accept -> (READ for mv) -> CAPT -> WB, sharing the regfile write
// ports with the ALU, which always wins unless the starvation guard fires.
// Optional build macro: BYPASS_STARVE_GUARD_EN (bounded WB stalls).
//
// Handshake: an op transfers on a cycle where op_valid && op_ready are both
// high; op_ready is high only in IDLE with no flush, and the op fields must
// be stable while op_valid is high.
import bypass_pkg::*;

module bypass_seq_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int MAX_STALL   = 4,
  parameter int STALL_CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_type,
  input  logic [ADDR_W-1:0] op_rd,
  input  logic [ADDR_W-1:0] op_rs1,
  input  logic [DATA_W-1:0] op_imm,
  input  logic              flush,
  output logic              int_rd_en,
  output logic              fp_rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        bypass_sel,
  output logic [DATA_W-1:0] imm_o,
  input  logic [DATA_W-1:0] bypass_result,
  input  logic              alu_int_wb_valid,
  input  logic              alu_fp_wb_valid,
  output logic              alu_wb_hold,
  output logic              int_wb_en,
  output logic              fp_wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              op_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // The stall counter must be able to hold MAX_STALL.
  if ((2 ** STALL_CNT_W) <= MAX_STALL) begin : g_bad_cfg
    $error("STALL_CNT_W too narrow for MAX_STALL");
  end

  state_t            state_q, state_d;
  logic [1:0]        type_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] result_q;
  logic              done_q;

  logic accept;
  logic dst_int;
  logic alu_conflict;
  logic force_grant;
  logic grant;

  assign accept       = op_valid && op_ready;
  assign dst_int      = dst_is_int(type_q);
  assign alu_conflict = dst_int ? alu_int_wb_valid : alu_fp_wb_valid;
  // Flush and reset both kill the write in the granting cycle.
  assign grant        = (state_q == ST_WB) && !flush && !rst &&
                        (!alu_conflict || force_grant);

`ifdef BYPASS_STARVE_GUARD_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  assign force_grant = (stall_cnt_q == STALL_CNT_W'(MAX_STALL));
  assign alu_wb_hold = (state_q == ST_WB) && force_grant && !flush && !rst;

  // Count consecutive WB stall cycles; any exit from WB clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_WB) && (state_d == ST_WB)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_q <= '0;
    end
  end
`else
  assign force_grant = 1'b0;
  assign alu_wb_hold = 1'b0;
`endif

  // Next-state logic; flush sends any active state straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (op_type == BYP_LUI)) begin
          state_d = ST_CAPT;
        end else if (accept && (op_type != BYP_NONE)) begin
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_WB;
      ST_WB:   if (grant) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // Per-state datapath controls; everything idles at zero outside its state.
  always_comb begin
    op_ready   = (state_q == ST_IDLE) && !flush;
    int_rd_en  = (state_q == ST_READ) && (type_q == BYP_MVWX) && !flush && !rst;
    fp_rd_en   = (state_q == ST_READ) && (type_q == BYP_MVXW) && !flush && !rst;
    rd_addr    = (state_q == ST_READ) ? rs1_q : '0;
    bypass_sel = (state_q == ST_CAPT) ? type_q : BYP_NONE;
    imm_o      = (state_q == ST_CAPT) ? imm_q : '0;
    int_wb_en  = grant && dst_int;
    fp_wb_en   = grant && !dst_int;
    wb_addr    = (state_q == ST_WB) ? rd_q : '0;
    wb_data    = (state_q == ST_WB) ? result_q : '0;
    op_done    = done_q;
    busy       = (state_q != ST_IDLE);
    state_dbg  = state_q;
  end

  // State, captured op fields, mux result and the completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      type_q   <= BYP_NONE;
      rd_q     <= '0;
      rs1_q    <= '0;
      imm_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q <= op_type;
        rd_q   <= op_rd;
        rs1_q  <= op_rs1;
        imm_q  <= op_imm;
      end
      if (state_q == ST_CAPT) begin
        result_q <= bypass_result;
      end
      done_q <= (accept && (op_type == BYP_NONE)) || grant;
    end
  end

endmodule
